// File: rtl/mcbsp_pkg.sv
// Shared constants and helpers for the McBSP0 slave transmit path.
// Frame length is clamped to the legal range so a bad register value cannot stall the frame counter.
package mcbsp_pkg;

   localparam int WORD_W = 32;
   localparam logic [6:0] MCBSP_LEN_MIN = 7'd2;
   localparam logic [6:0] MCBSP_LEN_MAX = 7'd32;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } tx_state_e;

   function automatic logic [6:0] clamp_len(input logic [6:0] len);
      if (len < MCBSP_LEN_MIN)
         return MCBSP_LEN_MIN;
      else if (len > MCBSP_LEN_MAX)
         return MCBSP_LEN_MAX;
      else
         return len;
   endfunction

endpackage

// File: rtl/mcbsp_tx_fifo.sv
// Single-clock show-ahead FIFO buffering words between the producer and the shift register.
// Pointers carry one extra bit so full and empty are distinguishable without a separate flag.
module mcbsp_tx_fifo #(
   parameter int AW = 2,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] wr_data,
   input  logic          pop,
   output logic [DW-1:0] rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

   logic [DW-1:0] mem [2**AW];
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic          do_push;
   logic          do_pop;

   assign level   = wptr - rptr;
   assign full    = (level == DEPTH);
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push)
            wptr <= wptr + ONE;
         if (do_pop)
            rptr <= rptr + ONE;
      end
   end

   // Storage is flushed by the pointer reset, so the array itself needs none.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/mcbsp0_slaver_tx.sv
// McBSP0 slave transmitter: shifts buffered words out MSB-first on miso, framed by the DSP's fsx.
// The next word's MSB sits on miso before fsx, so the DSP samples bit L-1-k on frame edge k.
module mcbsp0_slaver_tx
   import mcbsp_pkg::*;
#(
   parameter int FIFO_AW = 2,
   parameter int WORD_W  = mcbsp_pkg::WORD_W
) (
   input  logic               mcbsp_slaver_clkx,
   input  logic               mcbsp_slaver_rst,
   input  logic [6:0]         mcbsp_reg_length,
   input  logic               mcbsp_slaver_fsx,
   input  logic [WORD_W-1:0]  tx_data_in,
   input  logic               tx_valid_in,
   output logic               tx_ready_out,
   output logic               mcbsp_slaver_miso,
   output logic               tx_busy,
   output logic               tx_underrun,
   output logic [FIFO_AW:0]   tx_fifo_level,
   output logic [63:0]        debug_signal
);

   localparam int PAD_W = 64 - 44 - (FIFO_AW + 1);

   tx_state_e          state, state_n;
   logic [6:0]         cnt, cnt_n;
   logic [6:0]         len_q, len_n;
   logic [WORD_W-1:0]  shreg, shreg_n;
   logic               loaded, loaded_n;
   logic               underrun_n;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [WORD_W-1:0]  fifo_data;
   logic [6:0]         len_in;

   function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] d,
                                                    input logic [6:0] len);
      return d << (7'(WORD_W) - len);
   endfunction

   assign len_in = clamp_len(mcbsp_reg_length);

   mcbsp_tx_fifo #(
      .AW (FIFO_AW),
      .DW (WORD_W)
   ) u_fifo (
      .clk     (mcbsp_slaver_clkx),
      .rst     (mcbsp_slaver_rst),
      .push    (tx_valid_in),
      .wr_data (tx_data_in),
      .pop     (pop),
      .rd_data (fifo_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (tx_fifo_level)
   );

   always_ff @(posedge mcbsp_slaver_clkx or posedge mcbsp_slaver_rst) begin
      if (mcbsp_slaver_rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         len_q       <= MCBSP_LEN_MAX;
         shreg       <= '0;
         loaded      <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         len_q       <= len_n;
         shreg       <= shreg_n;
         loaded      <= loaded_n;
         tx_underrun <= underrun_n;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      len_n      = len_q;
      shreg_n    = shreg;
      loaded_n   = loaded;
      underrun_n = 1'b0;
      pop        = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (mcbsp_slaver_fsx) begin
               // An empty frame still runs its full length so the DSP stays bit-aligned.
               len_n    = len_in;
               cnt_n    = 7'd1;
               state_n  = ST_SHIFT;
               loaded_n = 1'b0;
               if (loaded) begin
                  shreg_n = shreg << 1;
               end else begin
                  shreg_n    = '0;
                  underrun_n = 1'b1;
               end
            end else if (!loaded && !fifo_empty) begin
               pop      = 1'b1;
               shreg_n  = align_word(fifo_data, len_in);
               loaded_n = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (cnt == len_q - 7'd1) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
               if (!fifo_empty) begin
                  pop      = 1'b1;
                  shreg_n  = align_word(fifo_data, len_in);
                  loaded_n = 1'b1;
               end else begin
                  shreg_n  = '0;
                  loaded_n = 1'b0;
               end
            end else begin
               shreg_n = shreg << 1;
               cnt_n   = cnt + 7'd1;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   assign tx_ready_out      = !fifo_full;
   assign mcbsp_slaver_miso = shreg[WORD_W-1];
   assign tx_busy           = (state == ST_SHIFT);

   assign debug_signal = {mcbsp_slaver_clkx, mcbsp_slaver_fsx, mcbsp_slaver_miso,
                          mcbsp_slaver_rst, state, cnt, shreg, tx_fifo_level,
                          {PAD_W{1'b0}}};

endmodule

// File: tb/tb_mcbsp0_slaver_tx.sv
// Directed bench for the McBSP0 slave transmitter: frames are captured at negedges, MSB first.
module tb_mcbsp0_slaver_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  len = 7'd32;
   logic        fsx = 1'b0;
   logic [31:0] tx_data = '0;
   logic        tx_valid = 1'b0;
   logic        ready;
   logic        miso;
   logic        busy;
   logic        underrun;
   logic [2:0]  level;
   logic [63:0] dbg;

   int checks = 0;
   int errors = 0;

   mcbsp0_slaver_tx #(.FIFO_AW(2), .WORD_W(32)) dut (
      .mcbsp_slaver_clkx (clk),
      .mcbsp_slaver_rst  (rst),
      .mcbsp_reg_length  (len),
      .mcbsp_slaver_fsx  (fsx),
      .tx_data_in        (tx_data),
      .tx_valid_in       (tx_valid),
      .tx_ready_out      (ready),
      .mcbsp_slaver_miso (miso),
      .tx_busy           (busy),
      .tx_underrun       (underrun),
      .tx_fifo_level     (level),
      .debug_signal      (dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic write_word(input logic [31:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Runs one frame of n bits; miso is sampled at the negedge before each frame edge.
   task automatic run_frame(input int n, input int wr_j, input logic [31:0] wr_d,
                            input int refsx_j, output logic [31:0] got,
                            output logic ur1, output logic ur2, output logic busy1);
      got = '0; ur1 = 1'b0; ur2 = 1'b0; busy1 = 1'b0;
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         fsx      = (j == 0) || (j == refsx_j);
         tx_valid = (j == wr_j);
         tx_data  = wr_d;
         got      = {got[30:0], miso};
         if (j == 1) begin ur1 = underrun; busy1 = busy; end
         if (j == 2) ur2 = underrun;
      end
      @(posedge clk);
      #1;
      fsx      = 1'b0;
      tx_valid = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", miso); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
      rst = 1'b0;
      len = 7'd32;
      write_word(32'h8000_0001);
      @(negedge clk);
      checks++; if (miso !== 1'b1) begin errors++; $display("FAIL preload_msb got %b want 1", miso); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL preload_level got %0d want 0", level); end
      rst = 1'b1;
      #1;
      checks++; if (miso !== 1'b0) begin errors++; $display("FAIL idle_rst_miso got %b want 0", miso); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL idle_rst_underrun got %b want 0", underrun); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_rst_ready got %b want 1", ready); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_len32;
      logic [31:0] got; logic ur1, ur2, b1;
      len = 7'd32;
      write_word(32'hA5A5_0F0F);
      run_frame(32, -1, 32'h0, -1, got, ur1, ur2, b1);
      checks++; if (got !== 32'hA5A5_0F0F) begin errors++; $display("FAIL len32_data got %h want a5a50f0f", got); end
      checks++; if (ur1 !== 1'b0) begin errors++; $display("FAIL len32_underrun got %b want 0", ur1); end
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL len32_busy got %b want 1", b1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len32_busy_end got %b want 0", busy); end
      checks++; if (miso !== 1'b0) begin errors++; $display("FAIL len32_miso_end got %b want 0", miso); end
   endtask

   task automatic test_len16;
      logic [31:0] got; logic ur1, ur2, b1;
      len = 7'd16;
      write_word(32'h1234_BEEF);
      run_frame(16, -1, 32'h0, -1, got, ur1, ur2, b1);
      checks++; if (got !== 32'h0000_BEEF) begin errors++; $display("FAIL len16_data got %h want 0000beef", got); end
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL len16_busy got %b want 1", b1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len16_busy_end got %b want 0", busy); end
      len = 7'd32;
   endtask

   task automatic test_back_to_back;
      logic [31:0] words [5];
      logic [31:0] got; logic ur1, ur2, b1;
      words[0] = 32'h0123_4567; words[1] = 32'h89AB_CDEF; words[2] = 32'hDEAD_BEEF;
      words[3] = 32'h5555_AAAA; words[4] = 32'hF00D_0001;
      len = 7'd32;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tx_data  = words[i];
         tx_valid = 1'b1;
      end
      @(negedge clk);
      tx_valid = 1'b0;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready got %b want 0", ready); end
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL b2b_level got %0d want 4", level); end
      for (int i = 0; i < 5; i++) begin
         run_frame(32, -1, 32'h0, -1, got, ur1, ur2, b1);
         checks++; if (got !== words[i]) begin errors++; $display("FAIL b2b_word%0d got %h want %h", i, got, words[i]); end
         checks++; if (ur1 !== 1'b0) begin errors++; $display("FAIL b2b_underrun%0d got %b want 0", i, ur1); end
      end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL b2b_level_end got %0d want 0", level); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_end got %b want 1", ready); end
   endtask

   task automatic test_underrun;
      logic [31:0] got; logic ur1, ur2, b1;
      len = 7'd32;
      run_frame(32, 3, 32'hCAFE_1234, -1, got, ur1, ur2, b1);
      checks++; if (got !== 32'h0) begin errors++; $display("FAIL ur_data got %h want 00000000", got); end
      checks++; if (ur1 !== 1'b1) begin errors++; $display("FAIL ur_pulse got %b want 1", ur1); end
      checks++; if (ur2 !== 1'b0) begin errors++; $display("FAIL ur_pulse_width got %b want 0", ur2); end
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL ur_busy got %b want 1", b1); end
      run_frame(32, -1, 32'h0, -1, got, ur1, ur2, b1);
      checks++; if (got !== 32'hCAFE_1234) begin errors++; $display("FAIL ur_next_data got %h want cafe1234", got); end
      checks++; if (ur1 !== 1'b0) begin errors++; $display("FAIL ur_next_underrun got %b want 0", ur1); end
   endtask

   task automatic test_refsx;
      logic [31:0] got; logic ur1, ur2, b1;
      len = 7'd32;
      write_word(32'h0F0F_5A5A);
      run_frame(32, -1, 32'h0, 10, got, ur1, ur2, b1);
      checks++; if (got !== 32'h0F0F_5A5A) begin errors++; $display("FAIL refsx_data got %h want 0f0f5a5a", got); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL refsx_busy_end got %b want 0", busy); end
   endtask

   task automatic test_rst_mid;
      logic [31:0] got; logic ur1, ur2, b1;
      len = 7'd32;
      write_word(32'hFFFF_FFFF);
      write_word(32'h1111_2222);
      for (int j = 0; j <= 10; j++) begin
         @(negedge clk);
         fsx = (j == 0);
      end
      checks++; if (miso !== 1'b1) begin errors++; $display("FAIL mid_miso_pre got %b want 1", miso); end
      checks++; if (level !== 3'd1) begin errors++; $display("FAIL mid_level_pre got %0d want 1", level); end
      rst = 1'b1;
      #1;
      checks++; if (miso !== 1'b0) begin errors++; $display("FAIL mid_rst_miso got %b want 0", miso); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_rst_level got %0d want 0", level); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
      @(negedge clk);
      rst = 1'b0;
      run_frame(32, -1, 32'h0, -1, got, ur1, ur2, b1);
      checks++; if (ur1 !== 1'b1) begin errors++; $display("FAIL mid_next_underrun got %b want 1", ur1); end
      checks++; if (got !== 32'h0) begin errors++; $display("FAIL mid_next_data got %h want 00000000", got); end
   endtask

   initial begin
      test_reset();
      test_len32();
      test_len16();
      test_back_to_back();
      test_underrun();
      test_refsx();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
